// File: rtl/row_clearer_pkg.sv
// Shared definitions for the row clearer: default board geometry, counter
// width and the 2-bit FSM state encoding.
package row_clearer_pkg;

  localparam int DEF_BLOCKS_WIDE = 10;  // bits per row
  localparam int DEF_BLOCKS_HIGH = 20;  // rows; row 0 is the top
  localparam int DEF_BITS_Y_POS  = 5;   // row index width
  localparam int DEF_BITS_LINES  = 10;  // cleared-line counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ZERO  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/row_clearer_sat_counter.sv
// Saturating up-counter for the cleared-line total.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, clears count
//   inc    in   add one this cycle (ignored once count is all ones)
//   count  out  current total
module row_clearer_sat_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/row_clearer.sv
// Removes one complete row from the fallen-pieces board: the board is copied
// into a working register, every row above the cleared one moves down one
// row per cycle, the top row is emptied and the result is written back with
// a one-cycle strobe. busy holds the row scanner off for the whole operation.
//
// Handshake: clear_req/clear_row is a level request. It is taken only in
// IDLE, while not paused and with clear_row inside the board; requests at
// any other time are dropped, not queued. fallen_out is valid only in the
// cycle fallen_we is high and holds its value otherwise.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   pause          freezes FSM, pointer, working register and counter
//   clear_req      row-complete flag from the scanner
//   clear_row      index of the complete row (0 = top)
//   fallen_in      current board, row r at bits [r*W +: W]
//   busy           high from accept through the write cycle
//   fallen_out     updated board
//   fallen_we      one-cycle write strobe for fallen_out
//   lines_cleared  saturating count of removed rows
//   state_dbg      current FSM state (row_clearer_pkg::state_t encoding)
module row_clearer
  import row_clearer_pkg::*;
#(
  parameter int BLOCKS_WIDE = DEF_BLOCKS_WIDE,
  parameter int BLOCKS_HIGH = DEF_BLOCKS_HIGH,
  parameter int BITS_Y_POS  = DEF_BITS_Y_POS,
  parameter int BITS_LINES  = DEF_BITS_LINES
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pause,
  input  logic                               clear_req,
  input  logic [BITS_Y_POS-1:0]              clear_row,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] fallen_in,
  output logic                               busy,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] fallen_out,
  output logic                               fallen_we,
  output logic [BITS_LINES-1:0]              lines_cleared,
  output logic [1:0]                         state_dbg
);

  localparam int BOARD_BITS = BLOCKS_WIDE * BLOCKS_HIGH;

  state_t                  state, state_next;
  logic [BOARD_BITS-1:0]   work;
  logic [BITS_Y_POS-1:0]   ptr;
  logic                    accept;
  int                      dst_base, src_base;

  assign accept    = (state == ST_IDLE) && clear_req &&
                     (32'(clear_row) < BLOCKS_HIGH);
  assign state_dbg = state;

  // Row being overwritten and the row above it; src is parked at 0 when the
  // pointer reaches the top so the select never leaves the register.
  assign dst_base = int'(ptr) * BLOCKS_WIDE;
  assign src_base = (ptr == '0) ? 0 : dst_base - BLOCKS_WIDE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fallen_we  = 1'b0;
    if (!pause) begin
      case (state)
        ST_IDLE:  if (accept) state_next = ST_SHIFT;
        ST_SHIFT: if (ptr == '0) state_next = ST_ZERO;
        ST_ZERO:  state_next = ST_WRITE;
        ST_WRITE: begin
          state_next = ST_IDLE;
          fallen_we  = 1'b1;
        end
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= '0;
      ptr        <= '0;
      busy       <= 1'b0;
      fallen_out <= '0;
    end else if (!pause) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            work <= fallen_in;
            ptr  <= clear_row;
            busy <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (ptr != '0) begin
            work[dst_base +: BLOCKS_WIDE] <= work[src_base +: BLOCKS_WIDE];
            ptr <= ptr - BITS_Y_POS'(1);
          end
        end
        ST_ZERO: begin
          // fallen_out is loaded with the finished board here so it is valid
          // throughout WRITE and then simply holds.
          work[BLOCKS_WIDE-1:0] <= '0;
          fallen_out <= {work[BOARD_BITS-1:BLOCKS_WIDE], {BLOCKS_WIDE{1'b0}}};
        end
        ST_WRITE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  row_clearer_sat_counter #(
    .WIDTH (BITS_LINES)
  ) u_lines (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fallen_we),
    .count (lines_cleared)
  );

endmodule

// File: tb/tb_row_clearer.sv
// Bench for row_clearer: directed scenarios plus randomized boards checked
// against a queue-based model of row removal.
module tb_row_clearer;

  localparam int W = 10;
  localparam int H = 20;
  localparam int N = W * H;
  localparam int YB = 5;
  localparam int LB = 10;
  localparam int LMAX = (1 << LB) - 1;

  logic          clk;
  logic          rst_n;
  logic          pause;
  logic          clear_req;
  logic [YB-1:0] clear_row;
  logic [N-1:0]  fallen_in;
  logic          busy;
  logic [N-1:0]  fallen_out;
  logic          fallen_we;
  logic [LB-1:0] lines_cleared;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_lines = 0;
  int we_total = 0;
  logic [N-1:0] exp_q[$];

  row_clearer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pause         (pause),
    .clear_req     (clear_req),
    .clear_row     (clear_row),
    .fallen_in     (fallen_in),
    .busy          (busy),
    .fallen_out    (fallen_out),
    .fallen_we     (fallen_we),
    .lines_cleared (lines_cleared),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Strobes as the board register would see them at the next rising edge.
  always @(negedge clk) begin
    #1;
    if (fallen_we === 1'b1) we_total++;
  end

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] model_clear(input logic [N-1:0] b, input int row);
    logic [W-1:0] rows[$];
    logic [N-1:0] res;
    for (int r = 0; r < H; r++) rows.push_back(b[r*W +: W]);
    rows.delete(row);
    rows.push_front('0);
    res = '0;
    for (int r = 0; r < H; r++) res[r*W +: W] = rows[r];
    return res;
  endfunction

  function automatic logic [N-1:0] rand_board();
    logic [N-1:0] b;
    for (int r = 0; r < H; r++) b[r*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    return b;
  endfunction

  function automatic void bump_lines();
    if (exp_lines < LMAX) exp_lines++;
  endfunction

  // ---------------- driver ----------------
  // Issues one clear and follows it until busy drops. Inputs are driven at
  // the falling edge and outputs sampled 1 time unit later.
  task automatic run_clear(input logic [N-1:0] board, input int row,
                           input int p_at, input int p_len, input bit overlap,
                           output logic [N-1:0] got, output int lat,
                           output int busy_n, output int strobes, output int we_paused);
    bit seen_we;
    got = '0; lat = -1; busy_n = 0; strobes = 0; we_paused = 0; seen_we = 0;
    @(negedge clk);
    fallen_in = board;
    clear_row = YB'(row);
    clear_req = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!overlap && k == 1) clear_req = 1'b0;
      if (overlap && k == 2) begin
        clear_row = YB'((row + 7) % H);
        fallen_in = ~board;
      end
      if (overlap && seen_we) clear_req = 1'b0;
      if (p_len > 0 && k == p_at) pause = 1'b1;
      if (p_len > 0 && k == p_at + p_len) pause = 1'b0;
      #1;
      if (busy === 1'b1) busy_n++;
      if (fallen_we === 1'b1) begin
        if (pause) we_paused++;
        else begin
          strobes++;
          seen_we = 1;
          got = fallen_out;
          if (lat < 0) lat = k - 1;
        end
      end
      if (busy !== 1'b1 && !pause) break;
    end
    pause = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic quick_clear_top();
    @(negedge clk);
    fallen_in = rand_board();
    clear_row = '0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
    end
    bump_lines();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [N-1:0] got; int lat, bn, st, wp, we0;
    rst_n = 1'b0; pause = 1'b0; clear_req = 1'b0; clear_row = '0; fallen_in = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (fallen_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", fallen_we); end
    n_checks++; if (lines_cleared !== '0) begin n_fail++; $display("FAIL reset_lines: got %0d want 0", lines_cleared); end
    n_checks++; if (fallen_out !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", fallen_out); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    @(negedge clk);
    rst_n = 1'b1;
    // one real clear so the abandoned one below starts from non-reset values
    fallen_in = rand_board();
    run_clear(fallen_in, 3, 0, 0, 0, got, lat, bn, st, wp);
    bump_lines();
    n_checks++; if (got !== model_clear(fallen_in, 3)) begin n_fail++; $display("FAIL pre_reset_board: got %h want %h", got, model_clear(fallen_in, 3)); end
    n_checks++; if (lines_cleared !== LB'(exp_lines)) begin n_fail++; $display("FAIL pre_reset_lines: got %0d want %0d", lines_cleared, exp_lines); end
    // abandon a row-19 clear mid-shift
    @(negedge clk);
    fallen_in = rand_board(); clear_row = 5'd19; clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midop_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    exp_lines = 0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_checks++; if (fallen_we !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %b want 0", fallen_we); end
    n_checks++; if (lines_cleared !== '0) begin n_fail++; $display("FAIL midreset_lines: got %0d want 0", lines_cleared); end
    n_checks++; if (fallen_out !== '0) begin n_fail++; $display("FAIL midreset_out: got %h want 0", fallen_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we0 = we_total;
    repeat (30) @(negedge clk);
    #1;
    n_checks++; if (we_total !== we0) begin n_fail++; $display("FAIL post_reset_strobe: got %0d strobes want 0", we_total - we0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_bottom_row();
    logic [N-1:0] b, got, exp; int lat, bn, st, wp;
    b = '0;
    b[19*W +: W] = 10'h3FF;
    b[18*W +: W] = 10'h155;
    exp = '0;
    exp[19*W +: W] = 10'h155;
    exp_q.push_back(exp);
    run_clear(b, 19, 0, 0, 0, got, lat, bn, st, wp);
    bump_lines();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL bottom_board: got %h want %h", got, exp); end
    n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL bottom_latency: got %0d want 21", lat); end
    n_checks++; if (bn !== 22) begin n_fail++; $display("FAIL bottom_busy_cycles: got %0d want 22", bn); end
    n_checks++; if (st !== 1) begin n_fail++; $display("FAIL bottom_strobes: got %0d want 1", st); end
    n_checks++; if (lines_cleared !== LB'(exp_lines)) begin n_fail++; $display("FAIL bottom_lines: got %0d want %0d", lines_cleared, exp_lines); end
  endtask

  task automatic test_top_row();
    logic [N-1:0] b, got, exp; int lat, bn, st, wp;
    b = '0;
    b[0*W +: W] = 10'h3FF;
    b[1*W +: W] = 10'h001;
    exp = '0;
    exp[1*W +: W] = 10'h001;
    run_clear(b, 0, 0, 0, 0, got, lat, bn, st, wp);
    bump_lines();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL top_board: got %h want %h", got, exp); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL top_latency: got %0d want 2", lat); end
    n_checks++; if (bn !== 3) begin n_fail++; $display("FAIL top_busy_cycles: got %0d want 3", bn); end
    n_checks++; if (lines_cleared !== LB'(exp_lines)) begin n_fail++; $display("FAIL top_lines: got %0d want %0d", lines_cleared, exp_lines); end
  endtask

  task automatic test_pause();
    logic [N-1:0] b, got, exp; int lat, bn, st, wp;
    // pause for 4 cycles while shifting a row-5 clear
    b = rand_board();
    exp = model_clear(b, 5);
    run_clear(b, 5, 2, 4, 0, got, lat, bn, st, wp);
    bump_lines();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL pause_shift_board: got %h want %h", got, exp); end
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL pause_shift_latency: got %0d want 11", lat); end
    n_checks++; if (bn !== 12) begin n_fail++; $display("FAIL pause_shift_busy: got %0d want 12", bn); end
    n_checks++; if (wp !== 0 || st !== 1) begin n_fail++; $display("FAIL pause_shift_strobes: got %0d/%0d paused want 1/0", st, wp); end
    n_checks++; if (lines_cleared !== LB'(exp_lines)) begin n_fail++; $display("FAIL pause_shift_lines: got %0d want %0d", lines_cleared, exp_lines); end
    // pause for 3 cycles exactly while in the write cycle of a row-0 clear
    b = rand_board();
    exp = model_clear(b, 0);
    run_clear(b, 0, 3, 3, 0, got, lat, bn, st, wp);
    bump_lines();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL pause_write_board: got %h want %h", got, exp); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL pause_write_latency: got %0d want 5", lat); end
    n_checks++; if (wp !== 0 || st !== 1) begin n_fail++; $display("FAIL pause_write_strobes: got %0d/%0d paused want 1/0", st, wp); end
    n_checks++; if (lines_cleared !== LB'(exp_lines)) begin n_fail++; $display("FAIL pause_write_lines: got %0d want %0d", lines_cleared, exp_lines); end
  endtask

  task automatic test_illegal_overlap();
    logic [N-1:0] b, got, exp; int lat, bn, st, wp, we0, busy_seen;
    we0 = we_total;
    busy_seen = 0;
    @(negedge clk);
    fallen_in = rand_board(); clear_row = 5'd25; clear_req = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (busy !== 1'b0) busy_seen++;
    end
    clear_req = 1'b0;
    n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL illegal_busy: got %0d busy cycles want 0", busy_seen); end
    n_checks++; if (we_total !== we0) begin n_fail++; $display("FAIL illegal_strobe: got %0d want 0", we_total - we0); end
    n_checks++; if (lines_cleared !== LB'(exp_lines)) begin n_fail++; $display("FAIL illegal_lines: got %0d want %0d", lines_cleared, exp_lines); end
    // request held with a new row and board while busy
    b = rand_board();
    exp = model_clear(b, 9);
    we0 = we_total;
    run_clear(b, 9, 0, 0, 1, got, lat, bn, st, wp);
    bump_lines();
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL overlap_board: got %h want %h", got, exp); end
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL overlap_latency: got %0d want 11", lat); end
    n_checks++; if (we_total - we0 !== 1) begin n_fail++; $display("FAIL overlap_strobes: got %0d want 1", we_total - we0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overlap_busy_after: got %b want 0", busy); end
    n_checks++; if (lines_cleared !== LB'(exp_lines)) begin n_fail++; $display("FAIL overlap_lines: got %0d want %0d", lines_cleared, exp_lines); end
  endtask

  task automatic test_random();
    logic [N-1:0] b, got, exp; int row, lat, bn, st, wp;
    for (int i = 0; i < 25; i++) begin
      b = rand_board();
      row = $urandom_range(0, H - 1);
      exp_q.push_back(model_clear(b, row));
      run_clear(b, row, 0, 0, 0, got, lat, bn, st, wp);
      bump_lines();
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rand_board[%0d] row %0d: got %h want %h", i, row, got, exp); end
      n_checks++; if (lat !== row + 2 || bn !== row + 3) begin n_fail++; $display("FAIL rand_timing[%0d] row %0d: got lat %0d busy %0d want %0d/%0d", i, row, lat, bn, row + 2, row + 3); end
      n_checks++; if (lines_cleared !== LB'(exp_lines)) begin n_fail++; $display("FAIL rand_lines[%0d]: got %0d want %0d", i, lines_cleared, exp_lines); end
    end
  endtask

  task automatic test_saturation();
    logic [N-1:0] b, got, exp; int lat, bn, st, wp;
    while (exp_lines < LMAX) quick_clear_top();
    #1;
    n_checks++; if (lines_cleared !== LB'(LMAX)) begin n_fail++; $display("FAIL sat_reach: got %0d want %0d", lines_cleared, LMAX); end
    b = rand_board();
    exp = model_clear(b, 4);
    run_clear(b, 4, 0, 0, 0, got, lat, bn, st, wp);
    bump_lines();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL sat_board: got %h want %h", got, exp); end
    n_checks++; if (lines_cleared !== LB'(exp_lines)) begin n_fail++; $display("FAIL sat_hold: got %0d want %0d", lines_cleared, exp_lines); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_bottom_row();
    test_top_row();
    test_pause();
    test_illegal_overlap();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
